// File: rtl/sgd_mem_rd_resp_if.sv
// AXI read-data (R) channel bundle between the memory interconnect and the
// SGD read-response block.
//   master : drives RVALID/RDATA/RID/RRESP/RLAST, samples RREADY (memory side)
//   slave  : samples the beat fields, drives RREADY (sgd_mem_rd_resp side)
interface sgd_mem_rd_resp_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 6
);
    logic                  m_axi_RVALID;
    logic [DATA_WIDTH-1:0] m_axi_RDATA;
    logic [ID_WIDTH-1:0]   m_axi_RID;
    logic [1:0]            m_axi_RRESP;
    logic                  m_axi_RLAST;
    logic                  m_axi_RREADY;

    modport master (
        output m_axi_RVALID,
        output m_axi_RDATA,
        output m_axi_RID,
        output m_axi_RRESP,
        output m_axi_RLAST,
        input  m_axi_RREADY
    );

    modport slave (
        input  m_axi_RVALID,
        input  m_axi_RDATA,
        input  m_axi_RID,
        input  m_axi_RRESP,
        input  m_axi_RLAST,
        output m_axi_RREADY
    );
endinterface

// File: rtl/sgd_mem_rd_resp.sv
// SGD training-data read-response path. Splits R beats by RID into the A
// (feature) stream through a 2-entry skid buffer and the B (label) stream
// through a line FIFO that is unpacked into one 32-bit label per sample.
// The label stream is trimmed at each epoch boundary; beats and protocol
// errors are counted for status registers.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   started             job start level; rising edge clears state and counters
//   number_of_samples   labels per epoch, latched on the started rising edge
//   r_if (slave)        AXI R channel (RVALID/RDATA/RID/RRESP/RLAST/RREADY)
//   a_data/a_valid/a_ready    A beat stream to the compute pipeline
//   b_label/b_valid/b_ready   label stream, one 32-bit label per handshake
//   num_a_beats, num_b_beats  accepted beat counters
//   num_rd_errors, rd_error   error beat counter and sticky error flag
module sgd_mem_rd_resp #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ID_WIDTH     = 6,
    parameter int unsigned A_TAG        = 0,
    parameter int unsigned B_TAG        = 1,
    parameter int unsigned B_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  started,
    input  logic [31:0]           number_of_samples,
    sgd_mem_rd_resp_if.slave      r_if,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [31:0]           b_label,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [31:0]           num_a_beats,
    output logic [31:0]           num_b_beats,
    output logic [31:0]           num_rd_errors,
    output logic                  rd_error
);

    localparam int unsigned LABELS = DATA_WIDTH / 32;
    localparam int unsigned IDX_W  = $clog2(LABELS);
    localparam int unsigned PTR_W  = $clog2(B_FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [ID_WIDTH-1:0] A_ID     = ID_WIDTH'(A_TAG);
    localparam logic [ID_WIDTH-1:0] B_ID     = ID_WIDTH'(B_TAG);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(LABELS - 1);
    localparam logic [CNT_W-1:0]    FIFO_MAX = CNT_W'(B_FIFO_DEPTH);

    // ---------------------------------------------------------------- state
    logic                  started_q;
    logic [31:0]           nsamp_q, nsamp_d;

    logic [1:0]            a_cnt_q, a_cnt_d;
    logic [DATA_WIDTH-1:0] a_head_q, a_head_d;
    logic [DATA_WIDTH-1:0] a_slot_q, a_slot_d;
    logic                  a_valid_q, a_valid_d;

    logic [DATA_WIDTH-1:0] b_mem_q [B_FIFO_DEPTH];
    logic [PTR_W-1:0]      b_wr_ptr_q, b_wr_ptr_d;
    logic [PTR_W-1:0]      b_rd_ptr_q, b_rd_ptr_d;
    logic [CNT_W-1:0]      b_cnt_q, b_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]           samp_q, samp_d;
    logic [31:0]           b_label_q, b_label_d;
    logic                  b_valid_q, b_valid_d;

    logic [31:0]           num_a_q, num_a_d;
    logic [31:0]           num_b_q, num_b_d;
    logic [31:0]           num_err_q, num_err_d;
    logic                  rd_error_q, rd_error_d;

    // ------------------------------------------------- beat classification
    logic is_a, is_b, a_space, fifo_full, rready;
    logic beat_acc, a_acc, b_acc, beat_err, start_pulse;

    assign start_pulse = started & ~started_q;
    assign is_a        = (r_if.m_axi_RID == A_ID);
    assign is_b        = (r_if.m_axi_RID == B_ID);
    assign a_space     = (a_cnt_q != 2'd2);
    assign fifo_full   = (b_cnt_q == FIFO_MAX);

    // Ready depends only on registered occupancy and the presented RID, so it
    // never waits for RVALID; unknown tags are always sunk.
    assign rready = rst_n & (is_a ? a_space : (is_b ? ~fifo_full : 1'b1));
    assign r_if.m_axi_RREADY = rready;

    assign beat_acc = r_if.m_axi_RVALID & rready;
    assign a_acc    = beat_acc & is_a;
    assign b_acc    = beat_acc & is_b;
    assign beat_err = beat_acc & ((~is_a & ~is_b) |
                                  (r_if.m_axi_RRESP != 2'b00) |
                                  ~r_if.m_axi_RLAST);

    // B FIFO write side shares the pointer base with the next-state logic.
    logic [PTR_W-1:0] b_wr_base;
    assign b_wr_base = start_pulse ? '0 : b_wr_ptr_q;

    // ------------------------------------------------------ next-state logic
    logic                  a_pop;
    logic [1:0]            a_cnt_base;
    logic                  b_hs, b_pop;
    logic [CNT_W-1:0]      b_cnt_base, b_cnt_left;
    logic [PTR_W-1:0]      b_rd_base;
    logic [IDX_W-1:0]      idx_base;
    logic [31:0]           samp_base, samp_inc;
    logic [DATA_WIDTH-1:0] head_line;

    always_comb begin
        nsamp_d    = nsamp_q;
        a_cnt_d    = a_cnt_q;
        a_head_d   = a_head_q;
        a_slot_d   = a_slot_q;
        a_valid_d  = a_valid_q;
        b_wr_ptr_d = b_wr_ptr_q;
        b_rd_ptr_d = b_rd_ptr_q;
        b_cnt_d    = b_cnt_q;
        idx_d      = idx_q;
        samp_d     = samp_q;
        b_label_d  = b_label_q;
        b_valid_d  = b_valid_q;
        num_a_d    = num_a_q;
        num_b_d    = num_b_q;
        num_err_d  = num_err_q;
        rd_error_d = rd_error_q;
        a_pop      = 1'b0;
        a_cnt_base = a_cnt_q;
        b_hs       = 1'b0;
        b_pop      = 1'b0;
        b_cnt_base = b_cnt_q;
        b_cnt_left = b_cnt_q;
        b_rd_base  = b_rd_ptr_q;
        idx_base   = idx_q;
        samp_base  = samp_q;
        samp_inc   = samp_q + 32'd1;
        head_line  = '0;

        // Job start: epoch length latched, 0 is treated as 1.
        if (start_pulse) begin
            nsamp_d = (number_of_samples == 32'd0) ? 32'd1 : number_of_samples;
        end

        // Start clears state first; a beat arriving in the same cycle lands
        // on the cleared state.
        a_cnt_base = start_pulse ? 2'd0 : a_cnt_q;
        b_cnt_base = start_pulse ? '0 : b_cnt_q;
        b_rd_base  = start_pulse ? '0 : b_rd_ptr_q;
        idx_base   = start_pulse ? '0 : idx_q;
        samp_base  = start_pulse ? 32'd0 : samp_q;

        // A skid buffer: head register drives a_data, second slot absorbs a
        // beat while the pipeline stalls.
        a_pop   = ~start_pulse & a_valid_q & a_ready;
        a_cnt_d = a_cnt_base;
        if (a_pop) begin
            a_head_d = a_slot_q;
            a_cnt_d  = a_cnt_base - 2'd1;
        end
        if (a_acc) begin
            if (a_cnt_d == 2'd0) a_head_d = r_if.m_axi_RDATA;
            else                 a_slot_d = r_if.m_axi_RDATA;
            a_cnt_d = a_cnt_d + 2'd1;
        end
        a_valid_d = (a_cnt_d != 2'd0);

        // Label unpack: advance on handshake, pop at line end or epoch end.
        b_hs   = ~start_pulse & b_valid_q & b_ready;
        idx_d  = idx_base;
        samp_d = samp_base;
        if (b_hs) begin
            if (samp_inc == nsamp_q) begin
                b_pop  = 1'b1;
                idx_d  = '0;
                samp_d = 32'd0;
            end else begin
                samp_d = samp_inc;
                if (idx_q == IDX_LAST) begin
                    b_pop = 1'b1;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end

        b_rd_ptr_d = b_rd_base + PTR_W'(b_pop);
        b_wr_ptr_d = b_wr_base + PTR_W'(b_acc);
        b_cnt_left = b_cnt_base - CNT_W'(b_pop);
        b_cnt_d    = b_cnt_left + CNT_W'(b_acc);

        // Registered label: the next head is the incoming line when the FIFO
        // would otherwise be empty, else the stored line at the next read ptr.
        head_line = (b_cnt_left == '0) ? r_if.m_axi_RDATA : b_mem_q[b_rd_ptr_d];
        b_valid_d = (b_cnt_d != '0);
        b_label_d = b_valid_d ? head_line[{idx_d, 5'd0} +: 32] : 32'd0;

        // Status counters; at most one error per beat.
        num_a_d    = (start_pulse ? 32'd0 : num_a_q)   + 32'(a_acc);
        num_b_d    = (start_pulse ? 32'd0 : num_b_q)   + 32'(b_acc);
        num_err_d  = (start_pulse ? 32'd0 : num_err_q) + 32'(beat_err);
        rd_error_d = (start_pulse ? 1'b0 : rd_error_q) | beat_err;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q  <= 1'b0;
            nsamp_q    <= 32'd1;
            a_cnt_q    <= 2'd0;
            a_head_q   <= '0;
            a_slot_q   <= '0;
            a_valid_q  <= 1'b0;
            b_wr_ptr_q <= '0;
            b_rd_ptr_q <= '0;
            b_cnt_q    <= '0;
            idx_q      <= '0;
            samp_q     <= 32'd0;
            b_label_q  <= 32'd0;
            b_valid_q  <= 1'b0;
            num_a_q    <= 32'd0;
            num_b_q    <= 32'd0;
            num_err_q  <= 32'd0;
            rd_error_q <= 1'b0;
        end else begin
            started_q  <= started;
            nsamp_q    <= nsamp_d;
            a_cnt_q    <= a_cnt_d;
            a_head_q   <= a_head_d;
            a_slot_q   <= a_slot_d;
            a_valid_q  <= a_valid_d;
            b_wr_ptr_q <= b_wr_ptr_d;
            b_rd_ptr_q <= b_rd_ptr_d;
            b_cnt_q    <= b_cnt_d;
            idx_q      <= idx_d;
            samp_q     <= samp_d;
            b_label_q  <= b_label_d;
            b_valid_q  <= b_valid_d;
            num_a_q    <= num_a_d;
            num_b_q    <= num_b_d;
            num_err_q  <= num_err_d;
            rd_error_q <= rd_error_d;
        end
    end

    // Line storage carries no reset; occupancy is tracked by b_cnt_q.
    always_ff @(posedge clk) begin
        if (b_acc) begin
            b_mem_q[b_wr_base] <= r_if.m_axi_RDATA;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign a_data        = a_head_q;
    assign a_valid       = a_valid_q;
    assign b_label       = b_label_q;
    assign b_valid       = b_valid_q;
    assign num_a_beats   = num_a_q;
    assign num_b_beats   = num_b_q;
    assign num_rd_errors = num_err_q;
    assign rd_error      = rd_error_q;

endmodule
